// File: rtl/iomem_word_bridge.sv
// Splits a 128-bit iomem block request into 32-bit req/gnt/rvalid word beats.
// Optional watchdog compiled in with `define IOMEM_BRIDGE_TIMEOUT_EN.
module iomem_word_bridge #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BLK_SIZE       = 128,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                iomem_valid_i,
    output logic                iomem_ready_o,
    input  logic [15:0]         iomem_wstrb_i,
    input  logic [XLEN-1:0]     iomem_addr_i,
    input  logic [BLK_SIZE-1:0] iomem_wdata_i,
    output logic [BLK_SIZE-1:0] iomem_rdata_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic                mem_we_o,
    output logic [3:0]          mem_be_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output logic                err_o
);
    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e              r_state, w_state_d;
    logic [1:0]          r_beat, w_beat_d;
    logic [XLEN-5:0]     r_addr_hi;
    logic [15:0]         r_wstrb;
    logic [BLK_SIZE-1:0] r_wdata, r_rdata, w_rdata_d;
    logic                w_is_write, w_in_req, w_timeout;
    logic [2:0]          w_first, w_next;
    logic [3:0]          w_unused_addr;

    // Returns {found, index} of the lowest beat >= from with a non-zero strobe nibble
    function automatic logic [2:0] find_beat(input logic [15:0] strb, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && strb[4*i +: 4] != 4'h0) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign w_first       = find_beat(iomem_wstrb_i, 3'd0);
    assign w_next        = find_beat(r_wstrb, {1'b0, r_beat} + 3'd1);
    assign w_is_write    = |r_wstrb;
    assign w_unused_addr = iomem_addr_i[3:0];

    always_comb begin
        w_state_d = r_state;
        w_beat_d  = r_beat;
        w_rdata_d = r_rdata;
        case (r_state)
            StIdle: begin
                if (iomem_valid_i) begin
                    w_state_d = StReq;
                    w_beat_d  = w_first[1:0];  // 0 when the request is a read
                end
            end
            StReq: begin
                if (mem_gnt_i) begin
                    if (!w_is_write)    w_state_d = StResp;
                    else if (w_next[2]) w_beat_d  = w_next[1:0];
                    else                w_state_d = StDone;
                end
            end
            StResp: begin
                if (mem_rvalid_i) begin
                    w_rdata_d[r_beat*XLEN +: XLEN] = mem_rdata_i;
                    if (r_beat == 2'd3) begin
                        w_state_d = StDone;
                    end else begin
                        w_beat_d  = r_beat + 2'd1;
                        w_state_d = StReq;
                    end
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (w_timeout) begin
            w_state_d = StDone;
            w_beat_d  = r_beat;
            w_rdata_d = r_rdata;
            if (!w_is_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= int'(r_beat)) w_rdata_d[i*XLEN +: XLEN] = XLEN'(32'hDEAD_BEEF);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= StIdle;
            r_beat    <= 2'd0;
            r_addr_hi <= '0;
            r_wstrb   <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_d;
            r_beat  <= w_beat_d;
            r_rdata <= w_rdata_d;
            if (r_state == StIdle && iomem_valid_i) begin
                r_addr_hi <= iomem_addr_i[XLEN-1:4];
                r_wstrb   <= iomem_wstrb_i;
                r_wdata   <= iomem_wdata_i;
            end
        end
    end

`ifdef IOMEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_err;

    assign w_timeout = (r_state == StReq || r_state == StResp) &&
                       (r_cnt == CntW'(TIMEOUT_CYCLES));

    // Restart the watchdog on every new beat phase
    always_comb begin
        w_cnt_d = r_cnt;
        if (w_state_d != r_state || w_beat_d != r_beat) w_cnt_d = '0;
        else if (r_state == StReq || r_state == StResp) w_cnt_d = r_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_d;
            if (w_timeout)              r_err <= 1'b1;
            else if (r_state == StDone) r_err <= 1'b0;
        end
    end

    assign err_o = (r_state == StDone) & r_err;
`else
    logic [31:0] w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = TIMEOUT_CYCLES;
    assign err_o        = 1'b0;
`endif

    assign w_in_req      = (r_state == StReq);
    assign mem_req_o     = w_in_req;
    assign mem_we_o      = w_in_req & w_is_write;
    assign mem_be_o      = !w_in_req ? 4'h0 :
                           (w_is_write ? r_wstrb[{r_beat, 2'b00} +: 4] : 4'hF);
    assign mem_addr_o    = w_in_req ? {r_addr_hi, r_beat, 2'b00} : '0;
    assign mem_wdata_o   = mem_we_o ? r_wdata[r_beat*XLEN +: XLEN] : '0;
    assign iomem_ready_o = (r_state == StDone);
    assign iomem_rdata_o = r_rdata;
endmodule

// File: tb/tb_iomem_word_bridge.sv
// Randomized bench for iomem_word_bridge: word-bus responder with stalls plus a block-level
// model of expected beats, read data and completion cycle.
module tb_iomem_word_bridge;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         iomem_valid_i, iomem_ready_o;
    logic [15:0]  iomem_wstrb_i;
    logic [31:0]  iomem_addr_i;
    logic [127:0] iomem_wdata_i, iomem_rdata_o;
    logic         mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, err_o;
    logic [3:0]   mem_be_o;
    logic [31:0]  mem_addr_o, mem_wdata_o, mem_rdata_i;

    iomem_word_bridge #(
        .XLEN          (32),
        .BLK_SIZE      (128),
        .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .iomem_valid_i(iomem_valid_i),
        .iomem_ready_o(iomem_ready_o),
        .iomem_wstrb_i(iomem_wstrb_i),
        .iomem_addr_i (iomem_addr_i),
        .iomem_wdata_i(iomem_wdata_i),
        .iomem_rdata_o(iomem_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [31:0] bus_ram [0:1023];
    logic [31:0] mdl_ram [0:1023];

    bit          rnd, drop_rv, pend, req_prev, busy;
    int          gcfg [4];
    int          rcfg [4];
    int          rv_wait, gwait, stalls, n_gnt, r_idx;
    logic [31:0] pend_data;
    logic [68:0] cur, bus_now;
    logic [68:0] beat_log [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int cfg);
        if (!rnd) return cfg;
        return ($urandom % 4 == 0) ? int'($urandom % 3) + 1 : 0;
    endfunction

    // Word-bus responder: decides gnt/rvalid for the coming edge, logs granted beats
    always @(negedge clk_i) begin
        busy         = pend;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        if (pend) begin
            if (rv_wait == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend_data;
                pend         = 1'b0;
            end else begin
                rv_wait--;
                stalls++;
            end
        end
        mem_gnt_i = 1'b0;
        if (!rst_ni) begin
            req_prev = 1'b0;
        end else if (mem_req_o) begin
            bus_now = {mem_we_o, mem_be_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'h0};
            check_eq("req_during_resp", busy, 0);
            if (!req_prev) begin
                cur   = bus_now;
                gwait = pick(gcfg[mem_addr_o[3:2]]);
            end else begin
                check_eq("beat_stable", bus_now, cur);
            end
            if (gwait == 0) begin
                mem_gnt_i = 1'b1;
                n_gnt++;
                beat_log.push_back(bus_now);
                req_prev = 1'b0;
                r_idx    = int'(mem_addr_o[11:2]);
                if (mem_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be_o[b]) bus_ram[r_idx][8*b +: 8] = mem_wdata_o[8*b +: 8];
                end else if (!drop_rv) begin
                    pend      = 1'b1;
                    pend_data = bus_ram[r_idx];
                    rv_wait   = pick(rcfg[mem_addr_o[3:2]]);
                end
            end else begin
                gwait--;
                stalls++;
                req_prev = 1'b1;
            end
        end else begin
            req_prev = 1'b0;
        end
    end

    // Call at a negedge; b2b means the current cycle is DONE and the next one is IDLE
    task automatic issue(input logic [31:0] a, input logic [15:0] s, input logic [127:0] wd,
                         input bit b2b);
        logic [31:0]  base;
        logic [68:0]  exp_q [$];
        logic [127:0] exp_rd;
        int           t0, lat, bidx;
        bit           done;
        base          = {a[31:4], 4'h0};
        bidx          = int'(base[11:2]);
        iomem_valid_i = 1'b1;
        iomem_addr_i  = a;
        iomem_wstrb_i = s;
        iomem_wdata_i = wd;
        t0            = b2b ? cyc + 1 : cyc;
        stalls        = 0;
        beat_log.delete();
        exp_rd = '0;
        for (int i = 0; i < 4; i++) begin
            if (s == 16'h0) begin
                exp_q.push_back({1'b0, 4'hF, base + 32'(4 * i), 32'h0});
                exp_rd[32*i +: 32] = mdl_ram[bidx + i];
            end else if (s[4*i +: 4] != 4'h0) begin
                exp_q.push_back({1'b1, s[4*i +: 4], base + 32'(4 * i), wd[32*i +: 32]});
            end
        end
        lat  = 1 + ((s == 16'h0) ? 8 : exp_q.size());
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk_i);
            done = iomem_ready_o;
        end
        check_eq("ready_seen", done, 1);
        if (done) begin
            check_eq("latency", cyc, t0 + lat + stalls);
            check_eq("err", err_o, 0);
            if (s == 16'h0) check_eq("rdata", iomem_rdata_o, exp_rd);
            check_eq("beat_count", beat_log.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < beat_log.size(); i++)
                check_eq("beat", beat_log[i], exp_q[i]);
        end
        for (int bt = 0; bt < 16; bt++)
            if (s[bt]) mdl_ram[bidx + bt/4][8*(bt%4) +: 8] = wd[8*bt +: 8];
    endtask

    task automatic finish_req();
        iomem_valid_i = 1'b0;
        iomem_wstrb_i = 16'($urandom);
        iomem_addr_i  = $urandom;
        @(negedge clk_i);
        check_eq("ready_pulse", iomem_ready_o, 0);
    endtask

    task automatic rand_req(output logic [31:0] a, output logic [15:0] s,
                            output logic [127:0] wd);
        a  = 32'h8000_0000 | ($urandom & 32'hFFF);
        wd = {$urandom, $urandom, $urandom, $urandom};
        s  = 16'h0;
        if ($urandom % 2 == 0) begin
            while (s == 16'h0) begin
                s = 16'($urandom);
                for (int i = 0; i < 4; i++) if ($urandom % 3 == 0) s[4*i +: 4] = 4'h0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0]  a;
        logic [15:0]  s;
        logic [127:0] wd;
        bit           at_done;
        bit           done;
        int           t0;
        iomem_valid_i = 1'b0;
        iomem_wstrb_i = '0;
        iomem_addr_i  = '0;
        iomem_wdata_i = '0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        rnd = 1'b0; drop_rv = 1'b0; pend = 1'b0; req_prev = 1'b0;
        n_gnt = 0; stalls = 0;
        for (int i = 0; i < 4; i++) begin gcfg[i] = 0; rcfg[i] = 0; end
        for (int i = 0; i < 1024; i++) begin bus_ram[i] = $urandom; mdl_ram[i] = bus_ram[i]; end

        #1;
        check_eq("reset_outputs", {iomem_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
                                   mem_wdata_o, err_o}, 0);
        check_eq("reset_rdata", iomem_rdata_o, 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Block read of the 0x8000_0010 block
        for (int i = 0; i < 4; i++) begin
            bus_ram[4 + i] = {8{4'(i + 1)}};
            mdl_ram[4 + i] = bus_ram[4 + i];
        end
        issue(32'h8000_0014, 16'h0, '0, 1'b0);
        check_eq("blk_read_const", iomem_rdata_o, 128'h44444444_33333333_22222222_11111111);
        finish_req();

        issue(32'h8000_0020, 16'h0F30, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 1'b0);
        finish_req();

        gcfg[1] = 3;
        issue(32'h8000_0040, 16'h0, '0, 1'b0);
        gcfg[1] = 0;
        finish_req();

        issue(32'h8000_0080, 16'h0, '0, 1'b0);
        issue(32'h8000_0084, 16'hFFFF, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b1);
        issue(32'h8000_0088, 16'h0, '0, 1'b1);
        finish_req();

        // Reset while beat 2 is waiting for rvalid; its rvalid arrives after release
        rcfg[2]       = 6;
        n_gnt         = 0;
        iomem_valid_i = 1'b1;
        iomem_addr_i  = 32'h8000_0100;
        iomem_wstrb_i = 16'h0;
        for (int k = 0; k < 100 && n_gnt < 3; k++) @(negedge clk_i);
        @(negedge clk_i);
        iomem_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check_eq("async_reset_outputs", {iomem_ready_o, mem_req_o, mem_we_o, mem_be_o,
                                         mem_addr_o, mem_wdata_o, err_o}, 0);
        check_eq("async_reset_rdata", iomem_rdata_o, 0);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        rcfg[2] = 0;
        repeat (8) begin
            @(negedge clk_i);
            check_eq("idle_after_reset", {mem_req_o, iomem_ready_o}, 0);
        end
        issue(32'h8000_0100, 16'h0, '0, 1'b0);
        finish_req();

`ifdef IOMEM_BRIDGE_TIMEOUT_EN
        drop_rv       = 1'b1;
        iomem_valid_i = 1'b1;
        iomem_addr_i  = 32'h8000_0200;
        iomem_wstrb_i = 16'h0;
        t0            = cyc;
        beat_log.delete();
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk_i);
            done = iomem_ready_o;
        end
        check_eq("tmo_ready_seen", done, 1);
        check_eq("tmo_latency", cyc, t0 + 11);
        check_eq("tmo_err", err_o, 1);
        check_eq("tmo_rdata", iomem_rdata_o, {4{32'hDEAD_BEEF}});
        check_eq("tmo_beats", beat_log.size(), 1);
        drop_rv = 1'b0;
        finish_req();
`endif

        rnd     = 1'b1;
        at_done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            rand_req(a, s, wd);
            if (at_done && ($urandom % 2 == 0)) begin
                issue(a, s, wd, 1'b1);
            end else begin
                if (at_done) finish_req();
                repeat ($urandom % 3) @(negedge clk_i);
                issue(a, s, wd, 1'b0);
            end
            at_done = 1'b1;
        end
        finish_req();
        rnd = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
